compare_monitor: RTL

Downstream consumer of the delayed-equality comparator. Samples the comparator's per-cycle `equal` flag after the comparator's pipeline has filled, then declares lock after a run of consecutive matches. After lock it counts mismatches and latches a sticky failure when a threshold is reached. Provides a start/stop-controlled checking session and status for software or testbench readout.

---
 rtl/compare_monitor.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/compare_monitor.sv
// rtl/compare_monitor.sv - lock/mismatch monitor for the delayed-equality comparator (optional COMPARE_MON_TSTAMP_EN)
module compare_monitor #(
  parameter int WARMUP_CYCLES = 3,
  parameter int LOCK_COUNT    = 16,
  parameter int ACQ_TIMEOUT   = 256,
  parameter int MAX_ERR       = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 equal,
  output logic                 busy,
  output logic                 locked,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] mismatch_count,
  output logic [2:0]           state
`ifdef COMPARE_MON_TSTAMP_EN
  ,
  output logic [CNT_WIDTH-1:0] first_err_cycle
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WARM_LAST = CNT_WIDTH'(WARMUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST  = CNT_WIDTH'(ACQ_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] ERR_LIMIT = CNT_WIDTH'(MAX_ERR);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] warm_q, warm_d;
  logic [CNT_WIDTH-1:0] run_q, run_d;
  logic [CNT_WIDTH-1:0] tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0] mm_q, mm_d;
  logic [CNT_WIDTH-1:0] mm_inc;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 locked_q, locked_d;

  // Saturating next value of the mismatch counter.
  always_comb begin
    mm_inc = (mm_q != CNT_MAX) ? mm_q + 1'b1 : mm_q;
  end

  // Next-state and counter updates; stop beats start, start restarts from any state.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    run_d   = run_q;
    tmo_d   = tmo_q;
    mm_d    = mm_q;
    err_d   = err_q;
    if (stop) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
      end
    end else if (start) begin
      state_d = ST_WARMUP;
      warm_d  = '0;
      run_d   = '0;
      tmo_d   = '0;
      mm_d    = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          if (warm_q == WARM_LAST) begin
            state_d = ST_ACQUIRE;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
        ST_ACQUIRE: begin
          tmo_d = tmo_q + 1'b1;
          if (equal) begin
            run_d = run_q + 1'b1;
            if (run_q == LOCK_LAST) begin
              state_d = ST_LOCKED;
            end
          end else begin
            run_d = '0;
          end
          // A lock completing on the timeout cycle takes priority.
          if (state_d != ST_LOCKED && tmo_q == TMO_LAST) begin
            state_d = ST_FAIL;
            err_d   = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!equal) begin
            mm_d = mm_inc;
            if (mm_inc == ERR_LIMIT) begin
              state_d = ST_FAIL;
              err_d   = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_comb begin
    busy_d   = (state_d == ST_WARMUP) || (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
    locked_d = (state_d == ST_LOCKED);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      warm_q   <= '0;
      run_q    <= '0;
      tmo_q    <= '0;
      mm_q     <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      mm_q     <= mm_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
    end
  end

  assign busy           = busy_q;
  assign locked         = locked_q;
  assign error          = err_q;
  assign mismatch_count = mm_q;
  assign state          = state_q;

`ifdef COMPARE_MON_TSTAMP_EN
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] fe_q, fe_d;
  logic                 first_mm;

  // The first mismatch the FSM actually counts in this session.
  assign first_mm = !stop && !start && (state_q == ST_LOCKED) && !equal && (mm_q == '0);

  // Session cycle counter and first-error timestamp capture.
  always_comb begin
    cyc_d = cyc_q;
    fe_d  = fe_q;
    if (start && !stop) begin
      cyc_d = '0;
      fe_d  = '0;
    end else begin
      if (busy_q && cyc_q != CNT_MAX) begin
        cyc_d = cyc_q + 1'b1;
      end
      if (first_mm) begin
        fe_d = cyc_q;
      end
    end
  end

  // Timestamp registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      fe_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      fe_q  <= fe_d;
    end
  end

  assign first_err_cycle = fe_q;
`endif

endmodule
